// File: rtl/mul_booth_mc_if.sv
// Issue/result handshake bundle for the multi-cycle Booth multiplier.
// master = producer/consumer side, slave = multiplier side.
interface mul_booth_mc_if #(
  parameter int DATA_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     op1;
  logic [DATA_W-1:0]     op2;
  logic                  op1_signed;
  logic                  op2_signed;
  logic [2*DATA_W-1:0]   dout_C;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_valid,
    output op1,
    output op2,
    output op1_signed,
    output op2_signed,
    output out_ready,
    input  in_ready,
    input  dout_C,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  op1,
    input  op2,
    input  op1_signed,
    input  op2_signed,
    input  out_ready,
    output in_ready,
    output dout_C,
    output out_valid
  );
endinterface

// File: rtl/mul_booth_mc.sv
// Multi-cycle radix-4 Booth multiplier, one digit per cycle,
// signed/unsigned per operand, registered result with backpressure.
module mul_booth_mc #(
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  mul_booth_mc_if.slave bus
);
  localparam int ITER = DATA_W / 2 + 1;
  localparam int XW   = DATA_W + 2;
  localparam int AW   = 2 * DATA_W + 4;
  localparam int PW   = 2 * DATA_W;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if ((DATA_W < 4) || (DATA_W % 2 != 0)) begin : g_bad_width
      $error("mul_booth_mc: DATA_W must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XW:0]     mplr_q, mplr_d;
  logic [PW-1:0]   dout_q, dout_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            last;
  logic            neg;
  logic [2:0]      trip;
  logic [AW-1:0]   mult;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   ext1;
  logic [XW-1:0]   ext2;

  assign bus.in_ready  = (state_q == S_IDLE) |
                         ((state_q == S_DONE) & bus.out_ready);
  assign bus.dout_C    = dout_q;
  assign bus.out_valid = out_valid_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (cnt_q == CW'(ITER - 1));

  assign ext1 = {{(AW - DATA_W){bus.op1_signed & bus.op1[DATA_W-1]}},
                 bus.op1};
  assign ext2 = {{2{bus.op2_signed & bus.op2[DATA_W-1]}}, bus.op2};

  // Multiplier shifts right two bits per cycle, so the live triplet
  // is always the bottom three bits; multiplicand shifts left to match.
  assign trip = mplr_q[2:0];

  always_comb begin
    mult = '0;
    neg  = 1'b0;
    unique case (trip)
      3'b001, 3'b010: mult = mcand_q;
      3'b011:         mult = mcand_q << 1;
      3'b100: begin
        mult = mcand_q << 1;
        neg  = 1'b1;
      end
      3'b101, 3'b110: begin
        mult = mcand_q;
        neg  = 1'b1;
      end
      default: mult = '0;
    endcase
  end

  assign sum = acc_q + (mult ^ {AW{neg}}) + AW'(neg);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplr_d      = mplr_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        acc_d   = sum;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          dout_d      = sum[PW-1:0];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the IDLE/DONE transitions above.
    if (accept) begin
      mcand_d = ext1;
      mplr_d  = {ext2, 1'b0};
      acc_d   = '0;
      cnt_d   = '0;
      state_d = S_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplr_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplr_q      <= mplr_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_mul_booth_mc.sv
// Bench for mul_booth_mc: directed cases plus random sweeps on an
// 8-bit and a 16-bit instance against an arithmetic product model.
module tb_mul_booth_mc;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mul_booth_mc_if #(.DATA_W(8))  b8 ();
  mul_booth_mc_if #(.DATA_W(16)) b16 ();

  mul_booth_mc #(.DATA_W(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  mul_booth_mc #(.DATA_W(16)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input int w,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input bit sa,
                                          input bit sb);
    longint av;
    longint bv;
    longint p;
    av = longint'({48'b0, a});
    bv = longint'({48'b0, b});
    if (sa && a[w-1]) av = av - (longint'(1) << w);
    if (sb && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- 8-bit instance helpers ----
  task automatic acc8(input logic [7:0] a, input logic [7:0] b,
                      input bit sa, input bit sb);
    b8.op1 = a; b8.op2 = b;
    b8.op1_signed = sa; b8.op2_signed = sb;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
  endtask

  // Waits for a result while driving ignored garbage on the issue side.
  task automatic wait8(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!b8.out_valid && n < 40) begin
      b8.in_valid = 1'($urandom);
      b8.op1 = 8'($urandom);
      b8.op2 = 8'($urandom);
      tick();
      n++;
    end
    b8.in_valid = 1'b0;
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_prod"}, {16'b0, b8.dout_C}, exp);
  endtask

  task automatic drain8(input string tag);
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    chk({tag, "_drain"}, b8.out_valid, 0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a,
                     input logic [7:0] b, input bit sa, input bit sb,
                     input int stall);
    acc8(a, b, sa, sb);
    wait8(tag, ref_mul(8, {8'b0, a}, {8'b0, b}, sa, sb));
    repeat (stall) tick();
    drain8(tag);
  endtask

  // ---- 16-bit instance helpers ----
  task automatic op16(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input bit sa, input bit sb,
                      input int stall);
    int n;
    b16.op1 = a; b16.op2 = b;
    b16.op1_signed = sa; b16.op2_signed = sb;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    n = 0;
    while (!b16.out_valid && n < 40) begin
      b16.in_valid = 1'($urandom);
      b16.op1 = 16'($urandom);
      b16.op2 = 16'($urandom);
      tick();
      n++;
    end
    b16.in_valid = 1'b0;
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_prod"}, b16.dout_C, ref_mul(16, a, b, sa, sb));
    repeat (stall) tick();
    b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    chk({tag, "_drain"}, b16.out_valid, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    b8.in_valid = 0; b8.op1 = 0; b8.op2 = 0;
    b8.op1_signed = 0; b8.op2_signed = 0; b8.out_ready = 0;
    b16.in_valid = 0; b16.op1 = 0; b16.op2 = 0;
    b16.op1_signed = 0; b16.op2_signed = 0; b16.out_ready = 0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst8_valid", b8.out_valid, 0);
    chk("rst8_dout", {16'b0, b8.dout_C}, 0);
    chk("rst8_ready", b8.in_ready, 1);
    chk("rst16_valid", b16.out_valid, 0);
    chk("rst16_dout", b16.dout_C, 0);
    chk("rst16_ready", b16.in_ready, 1);

    // Directed products, including the corner cases
    op8("ss_80x80", 8'h80, 8'h80, 1, 1, 0);
    chk("ss_80x80_const", ref_mul(8, 16'h80, 16'h80, 1, 1), 32'h4000);
    op8("uu_ffxff", 8'hFF, 8'hFF, 0, 0, 1);
    chk("uu_ffxff_const", ref_mul(8, 16'hFF, 16'hFF, 0, 0), 32'hFE01);

    // Mixed sign left pending for the backpressure test
    acc8(8'hFF, 8'hFF, 1, 0);
    wait8("su_ffxff", 32'hFF01);
    b8.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", b8.out_valid, 1);
      chk("bp_dout", {16'b0, b8.dout_C}, 32'hFF01);
      chk("bp_ready", b8.in_ready, 0);
    end
    // Consume and accept on the same edge
    b8.op1 = 8'h03; b8.op2 = 8'hFE;
    b8.op1_signed = 1; b8.op2_signed = 1;
    b8.out_ready = 1'b1;
    #1;
    chk("b2b_ready", b8.in_ready, 1);
    tick();
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b0;
    chk("b2b_consumed", b8.out_valid, 0);
    wait8("b2b", 32'hFFFA);
    drain8("b2b");

    // Reset mid-operation
    acc8(8'h7F, 8'h7F, 1, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", b8.out_valid, 0);
    chk("midrst_dout", {16'b0, b8.dout_C}, 0);
    chk("midrst_ready", b8.in_ready, 1);
    repeat (8) tick();
    chk("midrst_noresult", b8.out_valid, 0);
    op8("uu_5x6", 8'd5, 8'd6, 0, 0, 0);

    // Wide instance
    op16("w_8000x7fff", 16'h8000, 16'h7FFF, 1, 1, 0);
    op16("w_uu_max", 16'hFFFF, 16'hFFFF, 0, 0, 2);
    op16("w_us_max", 16'hFFFF, 16'h8000, 0, 1, 0);

    // Random sweeps over all mode combinations
    for (int i = 0; i < 2000; i++) begin
      op8("rnd8", 8'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 2000; i++) begin
      op16("rnd16", 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
